sysid_checker: RTL and testbench
================================

Name: sysid_checker

Overview:
- Avalon-MM read master directly downstream of the system-ID slave (control_slave).
- Reads word 0 (system ID) and word 1 (build timestamp) and latches both.
- Compares each against parameterised expected values and raises status flags.
- The boot controller and LEDs gate software start on id_ok/ts_ok.

Parameters:
- EXPECTED_ID, 32'h5000_0000, value expected at address 0.
- EXPECTED_TS, 32'h50EF_0B8F, value expected at address 1.
- READ_LATENCY, 0, cycles from accepted read to valid readdata (0 = same cycle).
- TIMEOUT_CYCLES, 255, maximum cycles waitrequest may stay high per read before error; must be ≥1.
- AUTO_START, 1, when 1 a check starts automatically on the first cycle after reset release.

Ports:
- clock  in  1  system clock; all logic rising-edge.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse requesting a (re)check; ignored unless state is IDLE, DONE or ERROR.
- sysid_address  out  1  slave word select: 0 = ID, 1 = timestamp.
- sysid_read  out  1  read strobe.
- sysid_waitrequest  in  1  slave stall; tie 0 for the sysid slave.
- sysid_readdata  in  32  slave read data.
- id_value  out  32  latched ID word.
- ts_value  out  32  latched timestamp word.
- id_ok  out  1  id_value == EXPECTED_ID.
- ts_ok  out  1  ts_value == EXPECTED_TS.
- busy  out  1  check in progress.
- done  out  1  one-cycle pulse when both words have been read.
- timeout_err  out  1  sticky bus-timeout flag.

Behaviour:
- Reset (reset_n=0 at a clock edge):
  - State = IDLE, or PEND if AUTO_START=1.
  - All outputs 0, including id_value/ts_value; latency and timeout counters 0.
  - Reset mid-transaction aborts immediately and sysid_read drops on the same edge.
- States:
  - IDLE: outputs stable. start moves to RD_ID.
  - PEND: one cycle, then RD_ID.
  - RD_ID: sysid_read=1, sysid_address=0, busy=1.
    - If waitrequest=0 this cycle, the read is accepted. If READ_LATENCY=0, sample readdata into id_value on this edge and go to RD_TS; otherwise go to LAT_ID.
    - If waitrequest=1, increment the timeout counter. At TIMEOUT_CYCLES go to ERROR.
  - LAT_ID: sysid_read=0. Count READ_LATENCY cycles; capture readdata on the cycle the count equals READ_LATENCY, then go to RD_TS.
  - RD_TS / LAT_TS: same as RD_ID / LAT_ID with sysid_address=1, capturing ts_value; then go to FIN.
  - FIN: one cycle. done=1, busy=0, id_ok/ts_ok updated. Then go to DONE.
  - DONE: hold results. start moves to RD_ID.
  - ERROR: timeout_err=1, busy=0, id_ok=ts_ok=0, captured values hold their last contents. start clears timeout_err and moves to RD_ID.
- Bus rules:
  - sysid_address is stable while sysid_read=1.
  - At most one outstanding read; sysid_read is never asserted in LAT_* states.
  - The timeout counter clears on each new read.
- Re-check behaviour: on re-check from DONE, id_ok/ts_ok drop to 0 on entry to RD_ID and are re-evaluated only in FIN. A partially completed check never shows stale ok flags.
- start asserted while busy is ignored, with no queuing.
- Timing: minimum check = 4 cycles from start to done pulse (RD_ID, RD_TS, FIN, then done seen) with READ_LATENCY=0 and waitrequest=0. Each waitstate adds 1 cycle; each latency cycle adds READ_LATENCY per word.
- The comparison is full 32-bit equality with no masking.

Test Plan:
- Reset release, AUTO_START=1, slave modelled as "address ? 32'h50EF0B8F : 32'h50000000":
  - → read at addr 0, then addr 1.
  - → id_value=0x50000000, ts_value=0x50EF0B8F, id_ok=ts_ok=1, single done pulse, busy low afterwards.
- Slave returns 0x50EF0B90 at addr 1 → ts_ok=0, id_ok=1, done pulses, no timeout_err.
- waitrequest held high 3 cycles on each read, TIMEOUT_CYCLES=255 → each sysid_read stays high 4 cycles with address stable, results correct.
- waitrequest stuck high, TIMEOUT_CYCLES=8 → ERROR after 8 stalled cycles, timeout_err=1, no done. A subsequent start with waitrequest=0 completes and clears timeout_err.
- READ_LATENCY=2 → read strobe is 1 cycle per word. Data is captured 2 cycles after acceptance; data driven at other cycles (0xDEADBEEF) is never captured.
- Reset asserted during LAT_TS, and start pulsed while busy:
  - → on reset, sysid_read and all flags go to 0 on that edge.
  - → start while busy causes no extra read and no second done.

Source files
------------

// File: rtl/sysid_checker.sv
// Avalon-MM read master that fetches the system-ID and build-timestamp words,
// latches them and flags whether they match the build the software expects.
module sysid_checker #(
    parameter logic [31:0] EXPECTED_ID    = 32'h5000_0000,
    parameter logic [31:0] EXPECTED_TS    = 32'h50EF_0B8F,
    parameter int unsigned READ_LATENCY   = 0,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter bit          AUTO_START     = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        sysid_address,
    output logic        sysid_read,
    input  logic        sysid_waitrequest,
    input  logic [31:0] sysid_readdata,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        busy,
    output logic        done,
    output logic        timeout_err
);

    localparam int TW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam int LW = (READ_LATENCY < 1) ? 1 : $clog2(READ_LATENCY + 1);
    localparam logic [TW-1:0] TO_LIMIT = TW'(TIMEOUT_CYCLES);
    localparam logic [LW-1:0] LAT_LAST = LW'(READ_LATENCY);

    typedef enum logic [3:0] {
        S_IDLE,
        S_PEND,
        S_RD_ID,
        S_LAT_ID,
        S_RD_TS,
        S_LAT_TS,
        S_FIN,
        S_DONE,
        S_ERROR
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] toCnt_q, toCnt_d;
    logic [LW-1:0] latCnt_q, latCnt_d;
    logic [31:0]   idValue_q, idValue_d;
    logic [31:0]   tsValue_q, tsValue_d;
    logic          idOk_q, idOk_d;
    logic          tsOk_q, tsOk_d;
    logic          done_q, done_d;
    logic          timeoutErr_q, timeoutErr_d;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q      <= AUTO_START ? S_PEND : S_IDLE;
            toCnt_q      <= '0;
            latCnt_q     <= '0;
            idValue_q    <= '0;
            tsValue_q    <= '0;
            idOk_q       <= 1'b0;
            tsOk_q       <= 1'b0;
            done_q       <= 1'b0;
            timeoutErr_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            toCnt_q      <= toCnt_d;
            latCnt_q     <= latCnt_d;
            idValue_q    <= idValue_d;
            tsValue_q    <= tsValue_d;
            idOk_q       <= idOk_d;
            tsOk_q       <= tsOk_d;
            done_q       <= done_d;
            timeoutErr_q <= timeoutErr_d;
        end
    end

    // Ok flags drop on every (re)start so a half-finished check never looks good.
    always_comb begin
        state_d      = state_q;
        toCnt_d      = toCnt_q;
        latCnt_d     = latCnt_q;
        idValue_d    = idValue_q;
        tsValue_d    = tsValue_q;
        idOk_d       = idOk_q;
        tsOk_d       = tsOk_q;
        done_d       = 1'b0;
        timeoutErr_d = timeoutErr_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_d      = S_RD_ID;
                    toCnt_d      = '0;
                    idOk_d       = 1'b0;
                    tsOk_d       = 1'b0;
                    timeoutErr_d = 1'b0;
                end
            end
            S_PEND: begin
                state_d = S_RD_ID;
                toCnt_d = '0;
            end
            S_RD_ID, S_RD_TS: begin
                if (!sysid_waitrequest) begin
                    toCnt_d = '0;
                    if (READ_LATENCY == 0) begin
                        if (state_q == S_RD_ID) begin
                            idValue_d = sysid_readdata;
                            state_d   = S_RD_TS;
                        end else begin
                            tsValue_d = sysid_readdata;
                            state_d   = S_FIN;
                        end
                    end else begin
                        latCnt_d = LW'(1);
                        state_d  = (state_q == S_RD_ID) ? S_LAT_ID : S_LAT_TS;
                    end
                end else begin
                    toCnt_d = toCnt_q + TW'(1);
                    if (toCnt_d == TO_LIMIT) begin
                        state_d      = S_ERROR;
                        toCnt_d      = '0;
                        timeoutErr_d = 1'b1;
                        idOk_d       = 1'b0;
                        tsOk_d       = 1'b0;
                    end
                end
            end
            // Slave data is only valid exactly READ_LATENCY cycles after acceptance.
            S_LAT_ID, S_LAT_TS: begin
                if (latCnt_q == LAT_LAST) begin
                    if (state_q == S_LAT_ID) begin
                        idValue_d = sysid_readdata;
                        state_d   = S_RD_TS;
                    end else begin
                        tsValue_d = sysid_readdata;
                        state_d   = S_FIN;
                    end
                    toCnt_d  = '0;
                    latCnt_d = '0;
                end else begin
                    latCnt_d = latCnt_q + LW'(1);
                end
            end
            S_FIN: begin
                done_d  = 1'b1;
                idOk_d  = (idValue_q == EXPECTED_ID);
                tsOk_d  = (tsValue_q == EXPECTED_TS);
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign sysid_read    = (state_q == S_RD_ID) || (state_q == S_RD_TS);
    assign sysid_address = (state_q == S_RD_TS) || (state_q == S_LAT_TS);
    assign busy          = (state_q == S_RD_ID) || (state_q == S_LAT_ID) ||
                           (state_q == S_RD_TS) || (state_q == S_LAT_TS);
    assign id_value      = idValue_q;
    assign ts_value      = tsValue_q;
    assign id_ok         = idOk_q;
    assign ts_ok         = tsOk_q;
    assign done          = done_q;
    assign timeout_err   = timeoutErr_q;

endmodule

// File: tb/tb_sysid_checker.sv
// Bench for sysid_checker: instance A uses zero latency with auto-start,
// instance B uses two-cycle read latency and an 8-cycle timeout.
module tb_sysid_checker;

    localparam logic [31:0] ID_WORD = 32'h5000_0000;
    localparam logic [31:0] TS_WORD = 32'h50EF_0B8F;
    localparam logic [31:0] JUNK    = 32'hDEAD_BEEF;

    typedef struct packed {
        logic [31:0] id;
        logic [31:0] ts;
        logic        idOk;
        logic        tsOk;
    } expect_t;

    expect_t sbA[$];
    expect_t sbB[$];
    int checks = 0;
    int errors = 0;

    logic        clock   = 1'b0;
    logic        reset_n = 1'b0;

    logic        startA = 1'b0, waitA = 1'b0;
    logic        addrA, readA, idOkA, tsOkA, busyA, doneA, toErrA;
    logic [31:0] rdataA, idValA, tsValA;
    logic [31:0] tsRespA = TS_WORD;

    logic        startB = 1'b0, waitB = 1'b0;
    logic        addrB, readB, idOkB, tsOkB, busyB, doneB, toErrB;
    logic [31:0] rdataB, idValB, tsValB;
    logic        p1B = 1'b0, p2B = 1'b0, a1B = 1'b0, a2B = 1'b0;

    always #5 clock = ~clock;

    assign rdataA = addrA ? tsRespA : ID_WORD;

    // Latency-2 slave: real data only on the second cycle after acceptance, junk otherwise.
    always @(posedge clock) begin
        p1B <= readB && !waitB;
        a1B <= addrB;
        p2B <= p1B;
        a2B <= a1B;
    end
    assign rdataB = p2B ? (a2B ? TS_WORD : ID_WORD) : JUNK;

    sysid_checker #(.READ_LATENCY(0), .TIMEOUT_CYCLES(255), .AUTO_START(1'b1)) dutA (
        .clock(clock), .reset_n(reset_n), .start(startA),
        .sysid_address(addrA), .sysid_read(readA),
        .sysid_waitrequest(waitA), .sysid_readdata(rdataA),
        .id_value(idValA), .ts_value(tsValA), .id_ok(idOkA), .ts_ok(tsOkA),
        .busy(busyA), .done(doneA), .timeout_err(toErrA)
    );

    sysid_checker #(.READ_LATENCY(2), .TIMEOUT_CYCLES(8), .AUTO_START(1'b0)) dutB (
        .clock(clock), .reset_n(reset_n), .start(startB),
        .sysid_address(addrB), .sysid_read(readB),
        .sysid_waitrequest(waitB), .sysid_readdata(rdataB),
        .id_value(idValB), .ts_value(tsValB), .id_ok(idOkB), .ts_ok(tsOkB),
        .busy(busyB), .done(doneB), .timeout_err(toErrB)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input bit selB);
        if (selB) startB = 1'b1;
        else      startA = 1'b1;
        tick();
        startA = 1'b0;
        startB = 1'b0;
    endtask

    task automatic stallRead(input logic expAddr, input int stalls);
        waitA = 1'b1;
        for (int k = 0; k < stalls; k++) begin
            checkOutput("stall read", readA, 1);
            checkOutput("stall addr", addrA, expAddr);
            tick();
        end
        waitA = 1'b0;
        checkOutput("accept read", readA, 1);
        checkOutput("accept addr", addrA, expAddr);
        tick();
    endtask

    task automatic waitDone(input bit selB, input int maxCycles, output int taken);
        expect_t e;
        bit      seen;
        string   tag;
        seen  = 1'b0;
        taken = 0;
        tag   = selB ? "B" : "A";
        while (!seen && taken < maxCycles) begin
            tick();
            taken++;
            seen = selB ? doneB : doneA;
        end
        checks++;
        assert (seen === 1'b1) else begin
            errors++;
            $error("[TB] FAIL done%s: no done pulse within %0d cycles, observed 0 expected 1", tag, maxCycles);
        end
        if (seen) begin
            e = selB ? sbB.pop_front() : sbA.pop_front();
            checkOutput({tag, " id_value"}, selB ? idValB : idValA, e.id);
            checkOutput({tag, " ts_value"}, selB ? tsValB : tsValA, e.ts);
            checkOutput({tag, " id_ok"}, selB ? idOkB : idOkA, e.idOk);
            checkOutput({tag, " ts_ok"}, selB ? tsOkB : tsOkA, e.tsOk);
            checkOutput({tag, " timeout_err"}, selB ? toErrB : toErrA, 0);
        end
    endtask

    initial begin
        int taken;
        int readCnt;
        int doneCnt;
        logic [0:5] expRead;
        logic [0:5] expAddr;

        $display("[TB] reset state");
        tick();
        tick();
        checkOutput("rst A read", readA, 0);
        checkOutput("rst A busy", busyA, 0);
        checkOutput("rst A done", doneA, 0);
        checkOutput("rst A id_value", idValA, 0);
        checkOutput("rst A id_ok", idOkA, 0);
        checkOutput("rst B read", readB, 0);
        checkOutput("rst B ts_value", tsValB, 0);
        checkOutput("rst B timeout_err", toErrB, 0);

        $display("[TB] auto-start check on A");
        sbA.push_back({ID_WORD, TS_WORD, 1'b1, 1'b1});
        reset_n = 1'b1;
        tick();
        checkOutput("auto RD_ID read", readA, 1);
        checkOutput("auto RD_ID addr", addrA, 0);
        checkOutput("auto RD_ID busy", busyA, 1);
        tick();
        checkOutput("auto RD_TS read", readA, 1);
        checkOutput("auto RD_TS addr", addrA, 1);
        checkOutput("auto RD_TS id_value", idValA, ID_WORD);
        waitDone(1'b0, 10, taken);
        checkOutput("auto done latency", taken, 2);
        tick();
        checkOutput("auto done single pulse", doneA, 0);
        checkOutput("auto busy after", busyA, 0);
        checkOutput("B idle during auto", readB, 0);

        $display("[TB] wrong timestamp on A");
        tsRespA = 32'h50EF_0B90;
        sbA.push_back({ID_WORD, 32'h50EF_0B90, 1'b1, 1'b0});
        applyStimulus(1'b0);
        checkOutput("recheck id_ok dropped", idOkA, 0);
        checkOutput("recheck ts_ok dropped", tsOkA, 0);
        waitDone(1'b0, 10, taken);
        checkOutput("min check cycles", taken + 1, 4);

        $display("[TB] waitstates on A");
        tsRespA = TS_WORD;
        sbA.push_back({ID_WORD, TS_WORD, 1'b1, 1'b1});
        applyStimulus(1'b0);
        stallRead(1'b0, 3);
        stallRead(1'b1, 3);
        checkOutput("waitstate read released", readA, 0);
        waitDone(1'b0, 10, taken);
        checkOutput("waitstate done latency", taken, 1);

        $display("[TB] stuck waitrequest on B");
        waitB = 1'b1;
        applyStimulus(1'b1);
        for (int i = 0; i < 8; i++) begin
            checkOutput("stuck read high", readB, 1);
            checkOutput("stuck no done", doneB, 0);
            checkOutput("stuck no err yet", toErrB, 0);
            tick();
        end
        checkOutput("timeout_err set", toErrB, 1);
        checkOutput("timeout busy low", busyB, 0);
        checkOutput("timeout read low", readB, 0);
        checkOutput("timeout id_ok", idOkB, 0);
        checkOutput("timeout no done", doneB, 0);
        tick();
        checkOutput("timeout_err sticky", toErrB, 1);

        $display("[TB] recovery and read latency on B");
        waitB = 1'b0;
        sbB.push_back({ID_WORD, TS_WORD, 1'b1, 1'b1});
        applyStimulus(1'b1);
        checkOutput("restart clears timeout_err", toErrB, 0);
        expRead = 6'b100100;
        expAddr = 6'b000111;
        for (int k = 0; k < 6; k++) begin
            checkOutput($sformatf("latency read cycle %0d", k), readB, expRead[k]);
            checkOutput($sformatf("latency addr cycle %0d", k), addrB, expAddr[k]);
            tick();
        end
        waitDone(1'b1, 5, taken);
        checkOutput("latency done timing", taken, 1);

        $display("[TB] start while busy on A");
        sbA.push_back({ID_WORD, TS_WORD, 1'b1, 1'b1});
        applyStimulus(1'b0);
        startA = 1'b1;
        tick();
        startA = 1'b0;
        waitDone(1'b0, 10, taken);
        readCnt = 0;
        doneCnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (readA) readCnt++;
            if (doneA) doneCnt++;
        end
        checkOutput("no queued read", readCnt, 0);
        checkOutput("no second done", doneCnt, 0);

        $display("[TB] reset during LAT_TS on B");
        applyStimulus(1'b1);
        for (int i = 0; i < 4; i++) tick();
        checkOutput("in LAT_TS addr", addrB, 1);
        checkOutput("in LAT_TS busy", busyB, 1);
        checkOutput("in LAT_TS read", readB, 0);
        reset_n = 1'b0;
        tick();
        checkOutput("abort B read", readB, 0);
        checkOutput("abort B addr", addrB, 0);
        checkOutput("abort B busy", busyB, 0);
        checkOutput("abort B done", doneB, 0);
        checkOutput("abort B id_value", idValB, 0);
        checkOutput("abort B ts_value", tsValB, 0);
        checkOutput("abort B id_ok", idOkB, 0);
        checkOutput("abort B ts_ok", tsOkB, 0);
        checkOutput("abort B timeout_err", toErrB, 0);

        $display("[TB] reset during RD_TS on A");
        reset_n = 1'b1;
        tick();
        tick();
        checkOutput("pre-abort A read", readA, 1);
        checkOutput("pre-abort A addr", addrA, 1);
        checkOutput("B stays idle", busyB, 0);
        reset_n = 1'b0;
        tick();
        checkOutput("abort A read", readA, 0);
        checkOutput("abort A addr", addrA, 0);
        checkOutput("abort A id_value", idValA, 0);
        checkOutput("abort A busy", busyA, 0);
        sbA.push_back({ID_WORD, TS_WORD, 1'b1, 1'b1});
        reset_n = 1'b1;
        waitDone(1'b0, 10, taken);
        checkOutput("post-reset auto latency", taken, 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
